// File: rtl/vga_sync_driver.sv
// VGA raster timing generator: h/v counters, 2-cycle delayed sync/blank, registered colour.
// Optional VGA_TEST_PATTERN_EN adds iPATTERN, which selects an internal 8-bar colour pattern.
module vga_sync_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       iVGA_CLK,
  input  logic       iRST,
  input  logic [9:0] iRed,
  input  logic [9:0] iGreen,
  input  logic [9:0] iBlue,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       iPATTERN,
`endif
  output logic [9:0] oVGA_X,
  output logic [9:0] oVGA_Y,
  output logic [9:0] oVGA_R,
  output logic [9:0] oVGA_G,
  output logic [9:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_N,
  output logic       oVGA_SYNC_N,
  output logic       oFRAME_TICK
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hs_s0;
  logic       vs_s0;
  logic       act_s0;
  logic       hs_d1;
  logic       vs_d1;
  logic       act_d1;
  logic [9:0] red_c;
  logic [9:0] grn_c;
  logic [9:0] blu_c;

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= 10'd0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign oVGA_X      = h_cnt;
  assign oVGA_Y      = v_cnt;
  assign oVGA_SYNC_N = 1'b0;
  assign oFRAME_TICK = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_comb begin
    hs_s0  = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
    vs_s0  = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
    act_s0 = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  end

  // First delay stage lines up with the pixel generator's own RGB register.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      hs_d1  <= 1'b1;
      vs_d1  <= 1'b1;
      act_d1 <= 1'b0;
    end else begin
      hs_d1  <= hs_s0;
      vs_d1  <= vs_s0;
      act_d1 <= act_s0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
  logic [9:0] h_d1;
  logic [2:0] bar;

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) h_d1 <= 10'd0;
    else      h_d1 <= h_cnt;
  end

  // Bar colour bits: R off for bars 2,3,6,7; G off for bars 4..7; B off for odd bars.
  always_comb begin
    bar   = 3'(h_d1 / BAR_W);
    red_c = iRed;
    grn_c = iGreen;
    blu_c = iBlue;
    if (iPATTERN) begin
      red_c = {10{~bar[1]}};
      grn_c = {10{~bar[2]}};
      blu_c = {10{~bar[0]}};
    end
  end
`else
  always_comb begin
    red_c = iRed;
    grn_c = iGreen;
    blu_c = iBlue;
  end
`endif

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      oVGA_R       <= 10'd0;
      oVGA_G       <= 10'd0;
      oVGA_B       <= 10'd0;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_N <= 1'b0;
    end else begin
      oVGA_R       <= act_d1 ? red_c : 10'd0;
      oVGA_G       <= act_d1 ? grn_c : 10'd0;
      oVGA_B       <= act_d1 ? blu_c : 10'd0;
      oVGA_HS      <= hs_d1;
      oVGA_VS      <= vs_d1;
      oVGA_BLANK_N <= act_d1;
    end
  end

endmodule
